// File: rtl/memory_access_controller_if.sv
// Request/response and data-memory signal bundle for memory_access_controller.
// Latency: none, pure wiring.
// Backpressure: ReqValid/ReqReady handshake, Busy mirrors the controller stall.
interface memory_access_controller_if;
  logic        ReqValid;
  logic        ReqWrite;
  logic        ReqWide;
  logic [31:0] ReqAddress;
  logic [31:0] ReqData;
  logic        ReqReady;
  logic        RespValid;
  logic [31:0] RespData;
  logic        RespFault;
  logic        Busy;
  logic [31:0] MemAddress;
  logic [15:0] MemDataIn;
  logic        MemRead;
  logic        MemWrite;
  logic [15:0] MemDataOut;

  // Controller side
  modport slave (
    input  ReqValid, ReqWrite, ReqWide, ReqAddress, ReqData, MemDataOut,
    output ReqReady, RespValid, RespData, RespFault, Busy,
           MemAddress, MemDataIn, MemRead, MemWrite
  );

  // Pipeline plus data memory side
  modport master (
    output ReqValid, ReqWrite, ReqWide, ReqAddress, ReqData, MemDataOut,
    input  ReqReady, RespValid, RespData, RespFault, Busy,
           MemAddress, MemDataIn, MemRead, MemWrite
  );
endinterface

// File: rtl/memory_access_controller.sv
// Splits 16/32-bit pipeline loads/stores into 16-bit data-memory accesses.
// Latency: response 2 cycles after accept (narrow), 3 (wide), 1 for a rejected request.
// Backpressure: ReqReady only in IDLE; Busy stalls the pipeline otherwise.
// Optional feature: define ADDR_CHECK_EN to reject addresses outside 0..0x7FF.
module memory_access_controller (
  input logic clk,
  input logic rst,
  memory_access_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;

  // Request captured at acceptance
  logic        lat_write;
  logic        lat_wide;
  logic [31:0] lat_addr;
  logic [15:0] lat_lo;

  // Word read during ACC0, forms the high half of a wide load
  logic [15:0] first_word;

  // Registered outputs
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [15:0] mem_din;

`ifdef ADDR_CHECK_EN
  logic resp_fault;
  logic req_bad;

  // The data memory spans 0..0x7FF; a wide access at 0x7FF would run past it
  assign req_bad = (bus.ReqAddress > 32'h0000_07FF) ||
                   (bus.ReqWide && (bus.ReqAddress == 32'h0000_07FF));
  assign bus.RespFault = resp_fault;
`else
  assign bus.RespFault = 1'b0;
`endif

  // Ready is state based; held low while reset is asserted
  assign bus.ReqReady   = (state == IDLE) && !rst;
  assign bus.Busy       = (state != IDLE);
  assign bus.RespValid  = resp_valid;
  assign bus.RespData   = resp_data;
  assign bus.MemRead    = mem_read;
  assign bus.MemWrite   = mem_write;
  assign bus.MemAddress = mem_addr;
  assign bus.MemDataIn  = mem_din;

  // Access sequencer: state, memory strobes and response, all registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lat_write  <= 1'b0;
      lat_wide   <= 1'b0;
      lat_addr   <= 32'h0;
      lat_lo     <= 16'h0;
      first_word <= 16'h0;
      resp_valid <= 1'b0;
      resp_data  <= 32'h0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= 32'h0;
      mem_din    <= 16'h0;
`ifdef ADDR_CHECK_EN
      resp_fault <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.ReqValid) begin
            lat_write <= bus.ReqWrite;
            lat_wide  <= bus.ReqWide;
            lat_addr  <= bus.ReqAddress;
            lat_lo    <= bus.ReqData[15:0];
            resp_data <= 32'h0;
`ifdef ADDR_CHECK_EN
            if (req_bad) begin
              // Rejected: straight to the response, memory untouched
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
            end else begin
`endif
              state     <= ACC0;
              mem_addr  <= bus.ReqAddress;
              // Big-endian: a wide access starts with the high half
              mem_din   <= bus.ReqWide ? bus.ReqData[31:16] : bus.ReqData[15:0];
              mem_write <= bus.ReqWrite;
              mem_read  <= !bus.ReqWrite;
`ifdef ADDR_CHECK_EN
            end
`endif
          end
        end

        ACC0: begin
          if (!lat_write) begin
            first_word <= bus.MemDataOut;
          end
          if (lat_wide) begin
            // Second half goes to the next word address, wrapping at 2^32
            state   <= ACC1;
            mem_addr <= lat_addr + 32'd1;
            mem_din  <= lat_lo;
          end else begin
            state      <= DONE;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            resp_valid <= 1'b1;
            resp_data  <= lat_write ? 32'h0 : {16'h0000, bus.MemDataOut};
          end
        end

        ACC1: begin
          state      <= DONE;
          mem_read   <= 1'b0;
          mem_write  <= 1'b0;
          resp_valid <= 1'b1;
          resp_data  <= lat_write ? 32'h0 : {first_word, bus.MemDataOut};
        end

        DONE: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
`ifdef ADDR_CHECK_EN
          resp_fault <= 1'b0;
`endif
        end

        default: begin
          state     <= IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_controller.sv
// Self-checking bench for memory_access_controller.
// Directed table, hand-written corner sequences, then randomized traffic vs a word-level model.
// Acts as both the pipeline and a 16-bit data memory with combinational read.
`timescale 1ns/1ps
module tb_memory_access_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  memory_access_controller_if bus();

  memory_access_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Data memory: synchronous write, combinational read
  logic [15:0] mem [0:4095] = '{default: 16'h0};
  always @(posedge clk) begin
    if (bus.MemWrite) mem[bus.MemAddress[11:0]] <= bus.MemDataIn;
  end
  assign bus.MemDataOut = bus.MemRead ? mem[bus.MemAddress[11:0]] : 16'h0;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [15:0] dat;
  } acc_t;

  acc_t trace[$];
  acc_t exp_trace[$];

  // Reference memory contents, word addressed
  logic [15:0] model [logic [31:0]];

  function automatic logic [15:0] m_rd(input logic [31:0] a);
    return model.exists(a) ? model[a] : 16'h0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Record every memory strobe cycle; strobes must be exclusive
  always @(negedge clk) begin
    if (bus.MemRead || bus.MemWrite) begin
      acc_t e;
      tests++;
      if (bus.MemRead && bus.MemWrite) begin
        fails++;
        $display("FAIL strobe_exclusive: MemRead=%b MemWrite=%b at %h", bus.MemRead, bus.MemWrite, bus.MemAddress);
      end
      e.wr   = bus.MemWrite;
      e.addr = bus.MemAddress;
      e.dat  = bus.MemWrite ? bus.MemDataIn : 16'h0;
      trace.push_back(e);
    end
  end

  // Word-level model of one request: expected response, latency and memory accesses
  task automatic model_req(input logic wr, input logic wide, input logic [31:0] addr,
                           input logic [31:0] data, output logic [31:0] ed,
                           output logic ef, output int el);
    logic        bad;
    logic [31:0] rd;
    int          n;
    bad = 1'b0;
`ifdef ADDR_CHECK_EN
    bad = (addr > 32'h7FF) || (wide && addr == 32'h7FF);
`endif
    exp_trace.delete();
    ed = 32'h0;
    ef = 1'b0;
    rd = 32'h0;
    if (bad) begin
      ef = 1'b1;
      el = 1;
    end else begin
      n  = wide ? 2 : 1;
      el = 1 + n;
      for (int i = 0; i < n; i++) begin
        acc_t        e;
        logic [31:0] a;
        logic [15:0] v;
        a = addr + i;
        v = (wide && i == 0) ? data[31:16] : data[15:0];
        e.wr   = wr;
        e.addr = a;
        e.dat  = wr ? v : 16'h0;
        exp_trace.push_back(e);
        if (wr) model[a] = v;
        else    rd = {rd[15:0], m_rd(a)};
      end
      ed = wr ? 32'h0 : rd;
    end
  endtask

  // Drive one request and wait for its response pulse
  task automatic do_req(input logic wr, input logic wide, input logic [31:0] addr,
                        input logic [31:0] data, output logic [31:0] rdata,
                        output logic flt, output int lat);
    int w;
    rdata = 32'h0;
    flt   = 1'b0;
    lat   = -1;
    @(negedge clk);
    trace.delete();
    bus.ReqValid   = 1'b1;
    bus.ReqWrite   = wr;
    bus.ReqWide    = wide;
    bus.ReqAddress = addr;
    bus.ReqData    = data;
    w = 0;
    while (!bus.ReqReady && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (!bus.ReqReady) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: ReqReady=%b required 1", bus.ReqReady);
      bus.ReqValid = 1'b0;
      return;
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) bus.ReqValid = 1'b0;
      if (bus.RespValid) begin
        lat   = k;
        rdata = bus.RespData;
        flt   = bus.RespFault;
        break;
      end
    end
    @(negedge clk);
    chk("resp_single_pulse", {31'h0, bus.RespValid}, 32'h0);
    chk("busy_after_done", {31'h0, bus.Busy}, 32'h0);
  endtask

  // Run one request through the model and the DUT, comparing everything
  task automatic exec(input string nm, input logic wr, input logic wide,
                      input logic [31:0] addr, input logic [31:0] data,
                      output logic [31:0] rdata, output logic flt, output int lat);
    logic [31:0] ed;
    logic        ef;
    int          el;
    model_req(wr, wide, addr, data, ed, ef, el);
    do_req(wr, wide, addr, data, rdata, flt, lat);
    chk({nm, "_data"}, rdata, ed);
    chk({nm, "_fault"}, {31'h0, flt}, {31'h0, ef});
    chk({nm, "_latency"}, lat, el);
    chk({nm, "_nacc"}, trace.size(), exp_trace.size());
    if (trace.size() == exp_trace.size()) begin
      foreach (exp_trace[i]) chk({nm, "_acc"}, {trace[i].wr, trace[i].addr[14:0], trace[i].dat},
                                 {exp_trace[i].wr, exp_trace[i].addr[14:0], exp_trace[i].dat});
    end
  endtask

  typedef struct {
    logic        wr;
    logic        wide;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_fault;
    int          exp_lat;
  } vec_t;

  initial begin
    vec_t        vt[8];
    logic [31:0] rdata;
    logic        flt;
    int          lat;
    bit          seen;

    bus.ReqValid   = 1'b0;
    bus.ReqWrite   = 1'b0;
    bus.ReqWide    = 1'b0;
    bus.ReqAddress = 32'h0;
    bus.ReqData    = 32'h0;

    // Reset state
    rst = 1'b1;
    #1;
    chk("rst_ready",   {31'h0, bus.ReqReady},  32'h0);
    chk("rst_busy",    {31'h0, bus.Busy},      32'h0);
    chk("rst_rvalid",  {31'h0, bus.RespValid}, 32'h0);
    chk("rst_rfault",  {31'h0, bus.RespFault}, 32'h0);
    chk("rst_rdata",   bus.RespData,           32'h0);
    chk("rst_maddr",   bus.MemAddress,         32'h0);
    chk("rst_mdin",    {16'h0, bus.MemDataIn}, 32'h0);
    chk("rst_strobes", {30'h0, bus.MemRead, bus.MemWrite}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'h0, bus.ReqReady}, 32'h1);

    // Directed vectors
    vt[0] = '{1'b1, 1'b0, 32'h1,   32'h0000FFFF, 32'h0,        1'b0, 2};
    vt[1] = '{1'b0, 1'b0, 32'h1,   32'h0,        32'h0000FFFF, 1'b0, 2};
    vt[2] = '{1'b1, 1'b1, 32'h8,   32'hDEADBEEF, 32'h0,        1'b0, 3};
    vt[3] = '{1'b0, 1'b1, 32'h8,   32'h0,        32'hDEADBEEF, 1'b0, 3};
    vt[4] = '{1'b1, 1'b0, 32'h7FF, 32'h0000EB5A, 32'h0,        1'b0, 2};
    vt[5] = '{1'b0, 1'b0, 32'h7FF, 32'h0,        32'h0000EB5A, 1'b0, 2};
    vt[6] = '{1'b0, 1'b1, 32'h8,   32'h0,        32'hDEADBEEF, 1'b0, 3};
`ifdef ADDR_CHECK_EN
    vt[7] = '{1'b0, 1'b1, 32'h7FF, 32'h0,        32'h0,        1'b1, 1};
`else
    vt[7] = '{1'b0, 1'b1, 32'h7FF, 32'h0,        32'hEB5A0000, 1'b0, 3};
`endif
    foreach (vt[i]) begin
      exec($sformatf("vec%0d", i), vt[i].wr, vt[i].wide, vt[i].addr, vt[i].data, rdata, flt, lat);
      chk($sformatf("vec%0d_tbl_data", i), rdata, vt[i].exp_data);
      chk($sformatf("vec%0d_tbl_fault", i), {31'h0, flt}, {31'h0, vt[i].exp_fault});
      chk($sformatf("vec%0d_tbl_lat", i), lat, vt[i].exp_lat);
    end

    // Back-to-back narrow loads with ReqValid held high
    @(negedge clk);
    bus.ReqValid = 1'b1; bus.ReqWrite = 1'b0; bus.ReqWide = 1'b0; bus.ReqAddress = 32'h1;
    chk("b2b_ready_idle", {31'h0, bus.ReqReady}, 32'h1);
    @(negedge clk);
    chk("b2b_ready_acc0", {31'h0, bus.ReqReady}, 32'h0);
    chk("b2b_busy_acc0",  {31'h0, bus.Busy},     32'h1);
    bus.ReqAddress = 32'h8;
    @(negedge clk);
    chk("b2b_ready_done", {31'h0, bus.ReqReady},  32'h0);
    chk("b2b_busy_done",  {31'h0, bus.Busy},      32'h1);
    chk("b2b_resp1_vld",  {31'h0, bus.RespValid}, 32'h1);
    chk("b2b_resp1_data", bus.RespData, {16'h0, m_rd(32'h1)});
    @(negedge clk);
    chk("b2b_ready_again", {31'h0, bus.ReqReady}, 32'h1);
    @(negedge clk);
    bus.ReqValid = 1'b0;
    chk("b2b_busy_acc0b",  {31'h0, bus.Busy},      32'h1);
    chk("b2b_no_resp",     {31'h0, bus.RespValid}, 32'h0);
    @(negedge clk);
    chk("b2b_resp2_vld",  {31'h0, bus.RespValid}, 32'h1);
    chk("b2b_resp2_data", bus.RespData, {16'h0, m_rd(32'h8)});
    @(negedge clk);
    chk("b2b_end", {31'h0, bus.RespValid}, 32'h0);

    // Reset during ACC1 of a wide store
    bus.ReqValid = 1'b1; bus.ReqWrite = 1'b1; bus.ReqWide = 1'b1;
    bus.ReqAddress = 32'h20; bus.ReqData = 32'h12345678;
    @(negedge clk);
    bus.ReqValid = 1'b0;
    chk("rst_seq_acc0", {bus.MemWrite, bus.MemAddress[14:0], bus.MemDataIn}, {1'b1, 15'h20, 16'h1234});
    @(negedge clk);
    chk("rst_seq_acc1", {bus.MemWrite, bus.MemAddress[14:0], bus.MemDataIn}, {1'b1, 15'h21, 16'h5678});
    rst = 1'b1;
    #1;
    chk("rst_seq_strobes", {30'h0, bus.MemRead, bus.MemWrite}, 32'h0);
    chk("rst_seq_busy",    {31'h0, bus.Busy},     32'h0);
    chk("rst_seq_ready",   {31'h0, bus.ReqReady}, 32'h0);
    chk("rst_seq_maddr",   bus.MemAddress, 32'h0);
    model[32'h20] = 16'h1234;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.RespValid) seen = 1'b1;
    end
    chk("rst_seq_no_resp", {31'h0, seen}, 32'h0);
    exec("after_rst_load", 1'b0, 1'b1, 32'h20, 32'h0, rdata, flt, lat);

    // Randomized traffic against the model
    for (int n = 0; n < 150; n++) begin
      logic        wr;
      logic        wide;
      logic [31:0] addr;
      int          r;
      wr   = 1'($urandom_range(0, 1));
      wide = 1'($urandom_range(0, 1));
      r    = $urandom_range(0, 9);
      if (r == 0)      addr = 32'h7FF;
      else if (r == 1) addr = 32'h7FE;
`ifdef ADDR_CHECK_EN
      else if (r == 2) addr = 32'h800 + $urandom_range(0, 32'h7FFF);
`endif
      else             addr = $urandom_range(0, 32'h7FF);
      exec("rand", wr, wide, addr, $urandom, rdata, flt, lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
